pantalla_framebuffer: RTL and testbench



---
 rtl/pantalla_framebuffer.sv | 161 ++++++++++++++++
 tb/tb_pantalla_framebuffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pantalla_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : pantalla_framebuffer
// Brief    : Double-buffered RGB444 pixel store feeding the panel scan path,
//            with frame-synchronous bank swap and hardware back-bank clear.
// Revision : 1.0
// ============================================================================
module pantalla_framebuffer #(
  parameter int COLS      = 64,
  parameter int ROW_PAIRS = 32,
  parameter int PWM_BITS  = 4,
  parameter int COL_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [COL_W-1:0] i_wr_x,
  input  logic [5:0]       i_wr_y,
  input  logic [11:0]      i_wr_rgb,
  input  logic             i_swap_req,
  input  logic             i_clear,
  input  logic             i_rd_en,
  input  logic [COL_W-1:0] i_rd_col,
  input  logic [4:0]       i_rd_row,
  input  logic [1:0]       i_rd_plane,
  input  logic             i_frame_end,
  output logic [1:0]       o_data_r,
  output logic [1:0]       o_data_g,
  output logic [1:0]       o_data_b,
  output logic             o_rd_valid,
  output logic             o_front,
  output logic             o_swap_pending,
  output logic             o_clear_busy
);

  localparam int DEPTH = ROW_PAIRS * COLS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic            clear_busy_q;
  logic            front_q, front_d;
  logic            pending_q, pending_d;
  logic            rd_valid_q;
  logic [1:0]      plane_q;
  logic            plane_ok_q;
  logic [11:0]     up_word_q, lo_word_q;

  // One array per panel half; bank is the upper address slice.
  logic [11:0] mem_up [0:2*DEPTH-1];
  logic [11:0] mem_lo [0:2*DEPTH-1];

  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ok, commit;

  function automatic logic [AW:0] bank_addr(input logic bank, input logic [AW-1:0] a);
    return (AW+1)'(bank) * (AW+1)'(DEPTH) + (AW+1)'(a);
  endfunction

  function automatic logic bit_of(input logic [11:0] w, input logic [3:0] base,
                                  input logic [1:0] p);
    return w[base + {2'b00, p}];
  endfunction

  assign wr_addr = AW'(i_wr_y[4:0]) * AW'(COLS) + AW'(i_wr_x);
  assign rd_addr = AW'(i_rd_row) * AW'(COLS) + AW'(i_rd_col);
  assign wr_ok   = i_wr_en && !clear_busy_q && ({1'b0, i_wr_x} < (COL_W+1)'(COLS));

  // Host writes and the clear sweep both target the bank not on display.
  always_ff @(posedge i_clk) begin
    if (clear_busy_q) begin
      mem_up[bank_addr(~front_q, clr_cnt_q)] <= '0;
      mem_lo[bank_addr(~front_q, clr_cnt_q)] <= '0;
    end else if (wr_ok) begin
      if (i_wr_y[5]) begin
        mem_lo[bank_addr(~front_q, wr_addr)] <= i_wr_rgb;
      end else begin
        mem_up[bank_addr(~front_q, wr_addr)] <= i_wr_rgb;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      up_word_q <= mem_up[bank_addr(front_q, rd_addr)];
      lo_word_q <= mem_lo[bank_addr(front_q, rd_addr)];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_clear) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q      <= ST_IDLE;
            clear_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A request arriving together with frame_end commits on that same edge.
  always_comb begin
    commit    = i_frame_end && (pending_q || i_swap_req) && !clear_busy_q;
    front_d   = front_q ^ commit;
    pending_d = commit ? 1'b0 : (pending_q | i_swap_req);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      plane_q    <= '0;
      plane_ok_q <= 1'b0;
    end else begin
      front_q    <= front_d;
      pending_q  <= pending_d;
      rd_valid_q <= i_rd_en;
      if (i_rd_en) begin
        plane_q    <= i_rd_plane;
        plane_ok_q <= ({1'b0, i_rd_plane} < 3'(PWM_BITS));
      end
    end
  end

  // plane_ok_q starts at 0, which also yields zero data out of reset.
  assign o_data_r = {bit_of(lo_word_q, 4'd8, plane_q), bit_of(up_word_q, 4'd8, plane_q)}
                    & {2{plane_ok_q}};
  assign o_data_g = {bit_of(lo_word_q, 4'd4, plane_q), bit_of(up_word_q, 4'd4, plane_q)}
                    & {2{plane_ok_q}};
  assign o_data_b = {bit_of(lo_word_q, 4'd0, plane_q), bit_of(up_word_q, 4'd0, plane_q)}
                    & {2{plane_ok_q}};

  assign o_rd_valid     = rd_valid_q;
  assign o_front        = front_q;
  assign o_swap_pending = pending_q;
  assign o_clear_busy   = clear_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pantalla_framebuffer.sv
`default_nettype none
// Testbench for pantalla_framebuffer: table vectors, corner sequences and
// random traffic against a frame-level reference model.
module tb_pantalla_framebuffer;
  localparam int COLS = 64, ROW_PAIRS = 32, PWM_BITS = 4, COL_W = 6;
  localparam int DEPTH = ROW_PAIRS * COLS;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 0, swap = 0, clr = 0, rd_en = 0, fe = 0;
  logic [5:0] wr_x = 0, wr_y = 0, rd_col = 0;
  logic [11:0] wr_rgb = 0;
  logic [4:0] rd_row = 0;
  logic [1:0] rd_plane = 0;
  logic [1:0] o_r, o_g, o_b;
  logic o_valid, o_front, o_pend, o_busy;

  always #5 clk = ~clk;

  pantalla_framebuffer #(.COLS(COLS), .ROW_PAIRS(ROW_PAIRS), .PWM_BITS(PWM_BITS), .COL_W(COL_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_x(wr_x), .i_wr_y(wr_y),
    .i_wr_rgb(wr_rgb), .i_swap_req(swap), .i_clear(clr), .i_rd_en(rd_en),
    .i_rd_col(rd_col), .i_rd_row(rd_row), .i_rd_plane(rd_plane), .i_frame_end(fe),
    .o_data_r(o_r), .o_data_g(o_g), .o_data_b(o_b), .o_rd_valid(o_valid),
    .o_front(o_front), .o_swap_pending(o_pend), .o_clear_busy(o_busy)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model: whole-frame arrays indexed [bank][half][row][col].
  logic [11:0] m [0:1][0:1][0:ROW_PAIRS-1][0:COLS-1];
  logic m_front = 0, m_pend = 0, m_valid = 0;
  logic [1:0] m_r = 0, m_g = 0, m_b = 0;
  int m_busy = 0;

  typedef struct {
    logic [5:0] x; logic [5:0] y; logic [11:0] rgb;
    logic [4:0] row; logic [5:0] col; logic [1:0] plane; logic [5:0] exp_rgb;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_bank(input int b);
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < ROW_PAIRS; r++)
        for (int c = 0; c < COLS; c++) m[b][h][r][c] = 12'h000;
  endtask

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_valid = 0; m_busy = 0;
    m_r = 0; m_g = 0; m_b = 0;
  endtask

  task automatic model_step();
    logic busy, commit;
    logic [11:0] up, lo;
    int p, bk;
    busy   = (m_busy > 0);
    commit = fe && (m_pend || swap) && !busy;
    if (rd_en) begin
      bk = int'(m_front);
      up = m[bk][0][rd_row][rd_col];
      lo = m[bk][1][rd_row][rd_col];
      p  = int'(rd_plane);
      if (p < PWM_BITS) begin
        m_r = {lo[8+p], up[8+p]}; m_g = {lo[4+p], up[4+p]}; m_b = {lo[p], up[p]};
      end else begin
        m_r = 0; m_g = 0; m_b = 0;
      end
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    if (wr_en && !busy && int'(wr_x) < COLS)
      m[int'(!m_front)][int'(wr_y[5])][wr_y[4:0]][wr_x] = wr_rgb;
    if (commit) begin
      m_front = !m_front; m_pend = 0;
    end else if (swap) begin
      m_pend = 1;
    end
    if (busy) m_busy--;
    else if (clr) begin
      m_busy = DEPTH;
      zero_bank(int'(!m_front));
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", {o_valid, o_r, o_g, o_b, o_front, o_pend, o_busy},
          {m_valid, m_r, m_g, m_b, m_front, m_pend, (m_busy > 0)});
  endtask

  task automatic idle();
    wr_en = 0; swap = 0; clr = 0; rd_en = 0; fe = 0;
  endtask

  task automatic read_px(input logic [4:0] row, input logic [5:0] col, input logic [1:0] pl);
    rd_en = 1; rd_row = row; rd_col = col; rd_plane = pl;
    cycle();
    rd_en = 0;
  endtask

  task automatic run_clear();
    clr = 1; cycle(); clr = 0;
    for (int i = 0; i < DEPTH + 100 && o_busy; i++) cycle();
    check("clear_done", o_busy, 1'b0);
  endtask

  initial begin
    logic f0;
    int busy_cycles, pend_cycles, toggles;
    logic prev_front;

    for (int b = 0; b < 2; b++) zero_bank(b);
    tbl[0] = '{6'd3,  6'd5,  12'hF0A, 5'd5,  6'd3,  2'd1, 6'b01_00_11};
    tbl[1] = '{6'd3,  6'd37, 12'h5C3, 5'd5,  6'd3,  2'd0, 6'b11_00_10};
    tbl[2] = '{6'd63, 6'd31, 12'h8F1, 5'd31, 6'd63, 2'd3, 6'b01_11_10};
    tbl[3] = '{6'd63, 6'd63, 12'h0C8, 5'd31, 6'd63, 2'd2, 6'b00_11_00};
    tbl[4] = '{6'd0,  6'd0,  12'hFFF, 5'd0,  6'd0,  2'd0, 6'b01_01_01};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {o_valid, o_r, o_g, o_b, o_front, o_pend, o_busy}, 10'd0);
    rst_n = 1;

    // Known contents in both banks
    run_clear();
    swap = 1; fe = 1; cycle(); idle();
    check("init_swap", o_front, 1'b1);
    run_clear();
    swap = 1; fe = 1; cycle(); idle();
    check("init_swap_back", o_front, 1'b0);

    // Table: write to back bank, verify isolation, commit, read back
    read_px(5'd0, 6'd0, 2'd0);
    check("iso_pre", {o_valid, o_r, o_g, o_b}, 7'b1_00_00_00);
    foreach (tbl[i]) begin
      wr_en = 1; wr_x = tbl[i].x; wr_y = tbl[i].y; wr_rgb = tbl[i].rgb;
      cycle();
    end
    wr_en = 0;
    read_px(5'd0, 6'd0, 2'd0);
    check("iso_back", {o_r, o_g, o_b}, 6'b00_00_00);
    swap = 1; fe = 1; rd_en = 1; rd_row = 0; rd_col = 0; rd_plane = 0;
    cycle(); idle();
    check("commit_cycle_old_front", {o_r, o_g, o_b}, 6'b00_00_00);
    check("commit_front", o_front, 1'b1);
    foreach (tbl[i]) begin
      read_px(tbl[i].row, tbl[i].col, tbl[i].plane);
      check($sformatf("tbl%0d_valid", i), o_valid, 1'b1);
      check($sformatf("tbl%0d_rgb", i), {o_r, o_g, o_b}, tbl[i].exp_rgb);
    end
    cycle();
    check("valid_drop", o_valid, 1'b0);
    check("data_hold", {o_r, o_g, o_b}, tbl[4].exp_rgb);

    // Swap deferral with a repeated request
    f0 = o_front; pend_cycles = 0; toggles = 0; prev_front = o_front;
    for (int t = 0; t <= 45; t++) begin
      swap = (t == 0 || t == 10);
      fe   = (t == 40);
      cycle();
      if (o_pend) pend_cycles++;
      if (o_front != prev_front) toggles++;
      prev_front = o_front;
    end
    idle();
    check("defer_pending_cycles", pend_cycles, 40);
    check("defer_toggles", toggles, 1);
    check("defer_front", o_front, !f0);

    // Clear: exact duration, dropped write, deferred swap
    f0 = o_front; busy_cycles = 0;
    clr = 1; cycle(); clr = 0;
    if (o_busy) busy_cycles++;
    for (int i = 0; i < 3000 && o_busy; i++) begin
      clr   = (i == 500);
      swap  = (i == 100);
      fe    = (i == 100 || i == 1500);
      wr_en = (i == 2040); wr_x = 0; wr_y = 0; wr_rgb = 12'hFFF;
      cycle();
      if (o_busy) busy_cycles++;
    end
    idle();
    check("clear_busy_cycles", busy_cycles, DEPTH);
    check("clear_no_swap", o_front, f0);
    check("clear_pending_kept", o_pend, 1'b1);
    fe = 1; cycle(); idle();
    check("post_clear_swap", o_front, !f0);
    read_px(5'd0, 6'd0, 2'd0);
    check("cleared_00", {o_r, o_g, o_b}, 6'd0);
    read_px(5'd5, 6'd3, 2'd1);
    check("cleared_53", {o_r, o_g, o_b}, 6'd0);
    read_px(5'd31, 6'd63, 2'd3);
    check("cleared_last", {o_r, o_g, o_b}, 6'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wr_en = $urandom_range(0, 1) == 1; wr_x = 6'($urandom); wr_y = 6'($urandom);
      wr_rgb = 12'($urandom);
      rd_en = $urandom_range(0, 1) == 1; rd_col = 6'($urandom); rd_row = 5'($urandom);
      rd_plane = 2'($urandom);
      swap = $urandom_range(0, 19) == 0;
      fe   = $urandom_range(0, 19) == 0;
      clr  = $urandom_range(0, 999) == 0;
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + 100 && o_busy; i++) cycle();
    check("rand_drain", o_busy, 1'b0);

    // Asynchronous reset in the middle of a clear with a swap pending
    clr = 1; cycle(); clr = 0;
    swap = 1; cycle(); swap = 0;
    repeat (998) cycle();
    #3 rst_n = 0;
    #1;
    check("rst_mid_clear", {o_valid, o_r, o_g, o_b, o_front, o_pend, o_busy}, 10'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    cycle();
    check("rst_idle", {o_front, o_busy}, 2'b00);
    run_clear();
    swap = 1; fe = 1; cycle(); idle();
    read_px(5'd17, 6'd40, 2'd2);
    check("rst_final_front", o_front, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
